// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder main-memory model.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois feedback mask for taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response channel; the cache is master, memory is slave.
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              reqValid;
  logic [ADDR_W-1:0] reqAddress;
  logic [DATA_W-1:0] reqDataIn;
  logic              reqWen;
  logic              respValid;
  logic [DATA_W-1:0] respDataOut;
  logic              busy;
  logic              protErr;

  modport master (
    output reqValid, reqAddress, reqDataIn, reqWen,
    input  respValid, respDataOut, busy, protErr
  );

  modport slave (
    input  reqValid, reqAddress, reqDataIn, reqWen,
    output respValid, respDataOut, busy, protErr
  );

endinterface

// File: rtl/mem_responder_lfsr16.sv
// 16-bit Galois LFSR advancing on enable; only built when MEM_RESPONDER_JITTER_EN is defined.
`ifdef MEM_RESPONDER_JITTER_EN
module lfsr16
  import mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule
`endif

// File: rtl/mem_responder.sv
// Word-addressed memory responder answering each request after a fixed latency.
// Optional MEM_RESPONDER_JITTER_EN adds 0-3 LFSR-chosen extra wait cycles per request.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 4);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, next_cnt, load_cnt;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic [1:0]        extra;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] last_q;
  logic              prot_err;
  logic              unused_addr_bits;

  assign idx              = bus.reqAddress[IDX_W+1:2];
  assign unused_addr_bits = ^{bus.reqAddress[ADDR_W-1:IDX_W+2], bus.reqAddress[1:0]};
  assign accept           = bus.reqValid && (state == IDLE);

`ifdef MEM_RESPONDER_JITTER_EN
  logic [15:0] lfsr_value;
  logic        unused_lfsr_bits;

  // The value present at acceptance sets that request's extra wait cycles.
  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .value (lfsr_value)
  );

  assign extra            = lfsr_value[1:0];
  assign unused_lfsr_bits = ^lfsr_value[15:2];
`else
  assign extra = 2'b00;
`endif

  assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (load_cnt == '0) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            next_cnt   = load_cnt;
          end
        end
      end
      WAIT: begin
        next_cnt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      prot_err <= 1'b0;
      last_q   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (bus.reqValid && (state != IDLE)) begin
        prot_err <= 1'b1;
      end
      if (state == RESP) begin
        last_q <= data_q;
      end
    end
  end

  // Store and data register have no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (bus.reqWen) begin
        mem[idx] <= bus.reqDataIn;
        data_q   <= bus.reqDataIn;
      end else begin
        data_q <= mem[idx];
      end
    end
  end

  assign bus.respValid   = (state == RESP);
  assign bus.busy        = (state != IDLE);
  assign bus.respDataOut = (state == RESP) ? data_q : last_q;
  assign bus.protErr     = prot_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, protocol/reset corners, random traffic.
module tb_mem_responder;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;
  localparam int NVEC    = 7;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wen;
    logic [31:0] expData;
  } vec_t;

  logic clk;
  logic rst;

  mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] refMem [int];
  int          writtenIdx [$];
  logic [15:0] refLfsr = 16'hACE1;
  vec_t        vecs [NVEC];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int wordIndex(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
    end
  endtask

  // Expected latency of the next accepted request; jitter uses the LFSR value current at acceptance.
  task automatic modelLatency(output int lat);
`ifdef MEM_RESPONDER_JITTER_EN
    lat = LATENCY + int'(refLfsr % 16'd4);
    refLfsr = refLfsr[0] ? ((refLfsr >> 1) ^ 16'hB400) : (refLfsr >> 1);
`else
    lat = LATENCY;
`endif
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic wen);
    @(negedge clk);
    bus.reqValid   = 1'b1;
    bus.reqAddress = addr;
    bus.reqDataIn  = data;
    bus.reqWen     = wen;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
  endtask

  task automatic awaitResp(input int startK, output int lat, output logic [31:0] data, output int busyCnt);
    lat     = 0;
    data    = '0;
    busyCnt = 0;
    for (int k = startK; k <= startK + 20; k++) begin
      if (bus.busy) busyCnt++;
      if (bus.respValid) begin
        lat  = k;
        data = bus.respDataOut;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runTxn(input string name, input logic [31:0] addr, input logic [31:0] data,
                        input logic wen, input logic [31:0] expData, input bit checkData);
    int          expLat;
    int          lat;
    int          busyCnt;
    logic [31:0] got;
    modelLatency(expLat);
    applyStimulus(addr, data, wen);
    awaitResp(1, lat, got, busyCnt);
    checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_busy_cycles"}, 32'(busyCnt), 32'(expLat));
`ifdef MEM_RESPONDER_JITTER_EN
    checkOutput({name, "_lat_range"}, 32'(lat >= LATENCY && lat <= LATENCY + 3), 32'd1);
`endif
    if (checkData) checkOutput({name, "_data"}, got, expData);
    @(posedge clk);
    #1;
    checkOutput({name, "_pulse_end"}, 32'(bus.respValid), 32'd0);
    checkOutput({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    if (checkData) checkOutput({name, "_hold"}, bus.respDataOut, expData);
    if (wen) begin
      refMem[wordIndex(addr)] = data;
      writtenIdx.push_back(wordIndex(addr));
    end
  endtask

  initial begin
    int          expLat;
    int          lat;
    int          busyCnt;
    int          respCount;
    logic [31:0] got;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expData;
    logic [31:0] idxMask;
    logic        wen;
    int          pick;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_0000, 32'h1111_1111, 1'b1, 32'h1111_1111};
    vecs[3] = '{32'h0000_1000, 32'h0000_0000, 1'b0, 32'h1111_1111};
    vecs[4] = '{32'h0000_0FFC, 32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F};
    vecs[5] = '{32'h0000_3FFC, 32'h0000_0000, 1'b0, 32'hA5A5_0F0F};
    vecs[6] = '{32'hFFFF_F013, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

    rst            = 1'b0;
    bus.reqValid   = 1'b0;
    bus.reqAddress = '0;
    bus.reqDataIn  = '0;
    bus.reqWen     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_respValid", 32'(bus.respValid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_protErr", 32'(bus.protErr), 32'd0);
    checkOutput("reset_respDataOut", bus.respDataOut, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] first read after reset");
    runTxn("first_read", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("first_read_protErr", 32'(bus.protErr), 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < NVEC; i++) begin
      runTxn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].wen, vecs[i].expData, 1'b1);
    end

    $display("[TB] request while busy");
    modelLatency(expLat);
    applyStimulus(32'h10, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.reqValid   = 1'b1;
    bus.reqWen     = 1'b1;
    bus.reqAddress = 32'h10;
    bus.reqDataIn  = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    checkOutput("prot_set", 32'(bus.protErr), 32'd1);
    awaitResp(3, lat, got, busyCnt);
    checkOutput("prot_first_latency", 32'(lat), 32'(expLat));
    checkOutput("prot_first_data", got, 32'hDEAD_BEEF);
    respCount = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.respValid) respCount++;
    end
    checkOutput("prot_no_second_resp", 32'(respCount), 32'd0);
    checkOutput("prot_sticky", 32'(bus.protErr), 32'd1);
    runTxn("prot_reread", 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    checkOutput("prot_still_sticky", 32'(bus.protErr), 32'd1);

    $display("[TB] reset during WAIT");
    modelLatency(expLat);
    applyStimulus(32'h20, 32'hCAFE_F00D, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_respValid", 32'(bus.respValid), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_protErr", 32'(bus.protErr), 32'd0);
    checkOutput("midrst_respDataOut", bus.respDataOut, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    refLfsr = 16'hACE1;
    refMem[wordIndex(32'h20)] = 32'hCAFE_F00D;
    writtenIdx.push_back(wordIndex(32'h20));
    respCount = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.respValid) respCount++;
    end
    checkOutput("midrst_no_resp", 32'(respCount), 32'd0);
    runTxn("midrst_reread", 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1);

    $display("[TB] random traffic");
    idxMask = 32'((DEPTH - 1) << 2);
    for (int i = 0; i < 50; i++) begin
      wen = ($urandom_range(0, 2) == 0) || (writtenIdx.size() == 0);
      if (wen) begin
        addr    = $urandom();
        data    = $urandom();
        expData = data;
      end else begin
        pick    = writtenIdx[$urandom_range(0, writtenIdx.size() - 1)];
        addr    = ($urandom() & ~idxMask) | (32'(pick) << 2);
        data    = $urandom();
        expData = refMem[pick];
      end
      runTxn($sformatf("rand%0d", i), addr, data, wen, expData, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory responder: the slave end of the cache-to-memory request/response channel.
- Accepts single-word read/write requests from the cache miss path (reqValid/reqAddress/reqDataIn/reqWen).
- Holds a word-addressed backing store and answers each request after a programmable latency with a one-cycle respValid pulse.
- Used as the memory model in cache-system simulation and as a synthesizable BRAM-backed memory.

Parameters:
- ADDR_W, 32, request address width in bits (byte address)
- DATA_W, 32, data word width in bits
- DEPTH, 1024, number of words in the store (power of two)
- LATENCY, 4, cycles from request acceptance to respValid (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- reqValid  in  1  one-cycle request pulse
- reqAddress  in  ADDR_W  byte address; word index = reqAddress[$clog2(DEPTH)+1:2]
- reqDataIn  in  DATA_W  write data
- reqWen  in  1  1 = write, 0 = read
- respValid  out  1  one-cycle response pulse
- respDataOut  out  DATA_W  read data, or write data echoed as write ack
- busy  out  1  request in flight; new requests are not accepted
- protErr  out  1  sticky: reqValid seen while busy

Behaviour:
- Reset (rst=0, async): state=IDLE, respValid=0, respDataOut=0, busy=0, protErr=0, counter=0. Store contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, reqValid=1:
  - Latch address index, data and wen; busy=1 next cycle.
  - A write commits to the store on the acceptance edge.
  - A read samples the store on the acceptance edge into a data register.
  - Load counter with LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
- WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reaches 0.
- RESP:
  - respValid=1 for exactly one cycle.
  - respDataOut = read data (read) or latched write data (write).
  - Then go to IDLE; busy=0 in the following cycle.
- Latency: the request accepted at edge N gives respValid high during cycle N+LATENCY.
- respDataOut holds its last value after respValid falls; it changes only in RESP.
- reqValid high while busy:
  - The request is ignored; protErr sets and stays set until reset.
  - The in-flight transaction is unaffected.
- Back-to-back requests: a new request is accepted in the first IDLE cycle, i.e. one cycle after the respValid cycle. Minimum request spacing is LATENCY+1 cycles.
- Read-after-write to the same word returns the new data, because the write commits at acceptance.
- Address bits above the index and bits [1:0] are ignored, so addresses wrap modulo DEPTH words.
- Reset mid-transaction:
  - The FSM returns to IDLE and no response is issued.
  - A write already committed at acceptance remains in the store.

Optional Feature:
- Macro MEM_RESPONDER_JITTER_EN.
- When defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every accepted request.
  - Its two LSBs add 0–3 extra WAIT cycles to that request, so latency ranges LATENCY..LATENCY+3.
- When undefined: no LFSR; latency is exactly LATENCY.

Decomposition:
- Package mem_responder_pkg:
  - State enum (IDLE, WAIT, RESP).
  - LFSR seed and tap constants.
  - Function computing index width from DEPTH.
- Natural sub-module: lfsr16, a free-running-on-enable LFSR, instantiated only under MEM_RESPONDER_JITTER_EN.

Test Plan:
- Reset then read addr 0x0 (LATENCY=4): respValid high exactly 4 cycles after acceptance; busy high 4 cycles; protErr=0.
- Write 0xDEADBEEF to 0x10, then read 0x10 at the earliest legal cycle: write ack echoes 0xDEADBEEF; read returns 0xDEADBEEF.
- Write 0x11111111 to 0x0, then read 0x1000 (DEPTH=1024, so it aliases to index 0): returns 0x11111111.
- Second reqValid two cycles after acceptance: protErr goes 1 and stays 1; the first response is unchanged; no second respValid.
- Assert rst low during WAIT: all outputs go 0 immediately; no respValid after release; the next read behaves normally.
- With MEM_RESPONDER_JITTER_EN, 50 reads: every latency lies within 4..7 and the sequence matches a reference LFSR model seeded with 16'hACE1.
